// File: rtl/axis_demux_if.sv
// AXI-Stream link carrying a one-bit destination sideband.
interface axis_demux_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tdest;

   modport master (output tdata, tvalid, tlast, tdest, input tready);
   modport slave  (input tdata, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/axis_demux.sv
// 1-to-2 AXI-Stream packet demux with a 2-entry elastic buffer and a route locked per packet.
module axis_demux #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 axis_aclk,
   input  logic                 axis_aresetn,
   axis_demux_if.slave          s_axis,
   axis_demux_if.master         m0_axis,
   axis_demux_if.master         m1_axis,
   output logic [CNT_WIDTH-1:0] pkt_cnt0,
   output logic [CNT_WIDTH-1:0] pkt_cnt1
);
   typedef struct packed {
      logic                  dest;
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, P0, P1} state_t;

   state_t     state, state_nxt;
   entry_t     buf_q [2];
   entry_t     head;
   logic       wr_ptr, rd_ptr;
   logic [1:0] count;
   logic       head_vld, accept, deliver, hs0, hs1, beat_dest;

   // Ready depends only on registered occupancy; the reset term keeps it low while held in reset.
   assign s_axis.tready = (count != 2'd2) && axis_aresetn;
   assign accept        = s_axis.tvalid & s_axis.tready;

   assign head     = buf_q[rd_ptr];
   assign head_vld = (count != 2'd0);

   assign m0_axis.tvalid = head_vld & ~head.dest;
   assign m1_axis.tvalid = head_vld &  head.dest;
   assign m0_axis.tdata  = head.data;
   assign m1_axis.tdata  = head.data;
   assign m0_axis.tlast  = head.last;
   assign m1_axis.tlast  = head.last;
   assign m0_axis.tdest  = 1'b0;
   assign m1_axis.tdest  = 1'b1;

   assign hs0     = m0_axis.tvalid & m0_axis.tready;
   assign hs1     = m1_axis.tvalid & m1_axis.tready;
   assign deliver = hs0 | hs1;

   always_comb begin
      state_nxt = state;
      beat_dest = s_axis.tdest;
      case (state)
         P0:      beat_dest = 1'b0;
         P1:      beat_dest = 1'b1;
         default: ;
      endcase
      if (accept) begin
         if (s_axis.tlast)       state_nxt = IDLE;
         else if (state == IDLE) state_nxt = s_axis.tdest ? P1 : P0;
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state    <= IDLE;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         state <= state_nxt;
         if (accept)  wr_ptr <= ~wr_ptr;
         if (deliver) rd_ptr <= ~rd_ptr;
         case ({accept, deliver})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
         if (hs0 && head.last) pkt_cnt0 <= pkt_cnt0 + 1'b1;
         if (hs1 && head.last) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge axis_aclk) begin
      if (accept) buf_q[wr_ptr] <= '{dest: beat_dest, last: s_axis.tlast, data: s_axis.tdata};
   end
endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux: routing, stalls, head-of-line blocking, counter wrap, reset.
module tb_axis_demux;
   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] cnt0, cnt1;
   int          checks = 0;
   int          passed = 0;

   axis_demux_if #(.DATA_WIDTH(32)) s_if ();
   axis_demux_if #(.DATA_WIDTH(32)) m0_if ();
   axis_demux_if #(.DATA_WIDTH(32)) m1_if ();

   axis_demux #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .axis_aclk    (clk),
      .axis_aresetn (rstn),
      .s_axis       (s_if),
      .m0_axis      (m0_if),
      .m1_axis      (m1_if),
      .pkt_cnt0     (cnt0),
      .pkt_cnt1     (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic dest, input logic last);
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tdest  = dest;
      s_if.tlast  = last;
   endtask

   task automatic do_reset();
      s_if.tvalid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("rst_tready", 32'(s_if.tready), 32'd0);
      chk("rst_m0_valid", 32'(m0_if.tvalid), 32'd0);
      chk("rst_m1_valid", 32'(m1_if.tvalid), 32'd0);
      chk("rst_cnt0", 32'(cnt0), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
      @(posedge clk);
      #3;
      rstn = 1'b1;
      #1;
      chk("post_rst_tready", 32'(s_if.tready), 32'd1);
      tick();
   endtask

   initial begin
      rstn = 1'b0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tdest = 1'b0; s_if.tlast = 1'b0;
      m0_if.tready = 1'b1;
      m1_if.tready = 1'b1;
      #2;
      do_reset();

      // 4-beat packet to port 1; later beats carry tdest=0, which must be ignored
      beat(32'hA0, 1'b1, 1'b0);
      tick();
      chk("p1_b0_valid", 32'(m1_if.tvalid), 32'd1);
      chk("p1_b0_data", m1_if.tdata, 32'hA0);
      chk("p1_b0_m0_valid", 32'(m0_if.tvalid), 32'd0);
      for (int i = 1; i < 4; i++) begin
         beat(32'hA0 + 32'(i), 1'b0, i == 3);
         tick();
         chk("p1_valid", 32'(m1_if.tvalid), 32'd1);
         chk("p1_data", m1_if.tdata, 32'hA0 + 32'(i));
         chk("p1_last", 32'(m1_if.tlast), 32'(i == 3));
         chk("p1_m0_valid", 32'(m0_if.tvalid), 32'd0);
         chk("p1_tready", 32'(s_if.tready), 32'd1);
      end
      s_if.tvalid = 1'b0;
      tick();
      chk("p1_drained", 32'(m1_if.tvalid), 32'd0);
      chk("p1_cnt1", 32'(cnt1), 32'd1);
      chk("p1_cnt0", 32'(cnt0), 32'd0);

      // back-to-back single-beat packets, dest 0,1,0
      do_reset();
      beat(32'hB0, 1'b0, 1'b1);
      tick();
      chk("sb0_m0_valid", 32'(m0_if.tvalid), 32'd1);
      chk("sb0_m0_data", m0_if.tdata, 32'hB0);
      chk("sb0_m1_valid", 32'(m1_if.tvalid), 32'd0);
      beat(32'hB1, 1'b1, 1'b1);
      tick();
      chk("sb1_m1_valid", 32'(m1_if.tvalid), 32'd1);
      chk("sb1_m1_data", m1_if.tdata, 32'hB1);
      chk("sb1_m0_valid", 32'(m0_if.tvalid), 32'd0);
      beat(32'hB2, 1'b0, 1'b1);
      tick();
      chk("sb2_m0_valid", 32'(m0_if.tvalid), 32'd1);
      chk("sb2_m0_data", m0_if.tdata, 32'hB2);
      s_if.tvalid = 1'b0;
      tick();
      chk("sb_cnt0", 32'(cnt0), 32'd2);
      chk("sb_cnt1", 32'(cnt1), 32'd1);

      // port-0 stall for 5 cycles: buffer fills at 2 beats, head stays stable
      m0_if.tready = 1'b0;
      beat(32'hC0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("st_m0_valid", 32'(m0_if.tvalid), 32'd1);
         chk("st_m0_data", m0_if.tdata, 32'hC0);
         chk("st_tready", 32'(s_if.tready), 32'(k == 0));
         if (k == 0) s_if.tdata = 32'hC1;
         if (k == 1) s_if.tdata = 32'hC2;
      end
      m0_if.tready = 1'b1;
      tick();
      chk("rel_data1", m0_if.tdata, 32'hC1);
      chk("rel_tready", 32'(s_if.tready), 32'd1);
      tick();
      chk("rel_data2", m0_if.tdata, 32'hC2);
      beat(32'hC3, 1'b0, 1'b1);
      tick();
      chk("rel_data3", m0_if.tdata, 32'hC3);
      chk("rel_last3", 32'(m0_if.tlast), 32'd1);
      s_if.tvalid = 1'b0;
      tick();
      chk("rel_drained", 32'(m0_if.tvalid), 32'd0);
      chk("rel_cnt0", 32'(cnt0), 32'd3);

      // port-1 packet stalled at head blocks a following port-0 packet
      m1_if.tready = 1'b0;
      beat(32'hD0, 1'b1, 1'b0);
      tick();
      beat(32'hD1, 1'b0, 1'b1);
      tick();
      beat(32'hE0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("hol_m0_valid", 32'(m0_if.tvalid), 32'd0);
         chk("hol_m1_data", m1_if.tdata, 32'hD0);
         tick();
      end
      m1_if.tready = 1'b1;
      tick();
      chk("hol_m1_d1", m1_if.tdata, 32'hD1);
      chk("hol_m0_still0", 32'(m0_if.tvalid), 32'd0);
      tick();
      chk("hol_m0_valid_e0", 32'(m0_if.tvalid), 32'd1);
      chk("hol_m0_data_e0", m0_if.tdata, 32'hE0);
      chk("hol_m1_idle", 32'(m1_if.tvalid), 32'd0);
      s_if.tvalid = 1'b0;
      tick();
      chk("hol_cnt1", 32'(cnt1), 32'd2);
      chk("hol_cnt0", 32'(cnt0), 32'd4);

      // counter wrap: 65536 single-beat packets on port 0
      do_reset();
      beat(32'h5A, 1'b0, 1'b1);
      for (int k = 0; k < 65536; k++) tick();
      chk("wrap_cnt0_max", 32'(cnt0), 32'hFFFF);
      s_if.tvalid = 1'b0;
      tick();
      chk("wrap_cnt0_zero", 32'(cnt0), 32'd0);

      // reset in the middle of a port-0 packet discards the open route
      beat(32'hF0, 1'b0, 1'b0);
      tick();
      beat(32'hF1, 1'b0, 1'b0);
      tick();
      chk("mid_m0_valid", 32'(m0_if.tvalid), 32'd1);
      do_reset();
      chk("mid_after_m0", 32'(m0_if.tvalid), 32'd0);
      beat(32'h61, 1'b1, 1'b1);
      tick();
      chk("mid_g0_m1_valid", 32'(m1_if.tvalid), 32'd1);
      chk("mid_g0_m1_data", m1_if.tdata, 32'h61);
      chk("mid_g0_m0_valid", 32'(m0_if.tvalid), 32'd0);
      s_if.tvalid = 1'b0;
      tick();
      chk("mid_cnt1", 32'(cnt1), 32'd1);
      chk("mid_cnt0", 32'(cnt0), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/axis_demux.md
AXIS_DEMUX -- requirements
Module: axis_demux

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all tdata buses.
REQ-002 Parameter CNT_WIDTH, default 16, width of per-port packet counters.
REQ-003 axis_aclk  input  1  clock; all state updates on the rising edge.
REQ-004 axis_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  DATA_WIDTH  slave data.
REQ-006 s_axis_tvalid  input  1  slave valid.
REQ-007 s_axis_tready  output  1  slave ready.
REQ-008 s_axis_tlast  input  1  slave end-of-packet.
REQ-009 s_axis_tdest  input  1  destination port; meaningful on the first beat of a packet only.
REQ-010 m0_axis_tdata, m1_axis_tdata  output  DATA_WIDTH  master data, ports 0 and 1.
REQ-011 m0_axis_tvalid, m1_axis_tvalid  output  1  master valid.
REQ-012 m0_axis_tready, m1_axis_tready  input  1  master ready.
REQ-013 m0_axis_tlast, m1_axis_tlast  output  1  master end-of-packet.
REQ-014 pkt_cnt0, pkt_cnt1  output  CNT_WIDTH  completed packets delivered on port 0 and port 1.

Function
REQ-015 The slave handshake SHALL complete on s_axis_tvalid & s_axis_tready; each master handshake SHALL complete on its tvalid & tready.
REQ-016 The block SHALL hold a 2-entry elastic buffer; each entry stores {dest, tlast, tdata}.
REQ-017 s_axis_tready SHALL be a registered signal, high when fewer than 2 entries are occupied at the start of the cycle, with no combinational path from any m*_axis_tready.
REQ-018 A beat accepted at edge N SHALL be visible on the selected master port at edge N+1 (1-cycle latency).
REQ-019 Sustained throughput SHALL be 1 beat/cycle while the destination port is ready.
REQ-020 Routing FSM states: IDLE (no packet open), P0 (packet open to port 0), P1 (packet open to port 1); reset state IDLE.
REQ-021 In IDLE, an accepted beat SHALL take dest = s_axis_tdest; if tlast=0 the FSM moves to P0 or P1 per dest, and if tlast=1 (single-beat packet) it stays IDLE.
REQ-022 In P0/P1, an accepted beat SHALL take the locked dest and SHALL ignore s_axis_tdest; an accepted beat with tlast=1 returns the FSM to IDLE.
REQ-023 The buffer head SHALL drive tvalid only on the port named by its dest; the other port's tvalid SHALL be 0.
REQ-024 tdata and tlast of both ports SHALL carry the head entry's data; consumers qualify them with their own tvalid.
REQ-025 A stalled head SHALL block all later beats (in-order, head-of-line blocking); no reordering between ports.
REQ-026 Beats SHALL never be dropped, duplicated or reordered; tdata/tlast on a port SHALL be stable while tvalid=1 and tready=0.
REQ-027 Simultaneous accept and deliver with 2 entries occupied SHALL NOT occur, because tready is low; with 1 entry occupied, both SHALL proceed and occupancy stays 1.
REQ-028 pkt_cntN SHALL increment by 1 on each port-N handshake with tlast=1, and SHALL wrap from 2^CNT_WIDTH-1 to 0.

Reset
REQ-029 While axis_aresetn=0: s_axis_tready=0, m0/m1_axis_tvalid=0, both buffer entries empty, FSM=IDLE, pkt_cnt0=pkt_cnt1=0.
REQ-030 s_axis_tready SHALL be 1 in the first cycle after axis_aresetn deasserts.
REQ-031 Reset mid-packet SHALL discard buffered beats and the open route; the next accepted beat SHALL be treated as a first beat.
REQ-032 Deassertion SHALL be synchronised by the integrator; the block requires only an async-assert reset.

Verification
REQ-033 4-beat packet 0xA0..0xA3 with tdest=1 on beat 0 and tdest=0 on beats 1-3, m1 always ready -> all 4 beats appear on m1 at 1 beat/cycle with 1-cycle latency, m0_axis_tvalid=0 throughout, pkt_cnt1=1.
REQ-034 Back-to-back single-beat packets with tdest 0,1,0 -> beats delivered in order on m0, m1, m0, and pkt_cnt0=2, pkt_cnt1=1.
REQ-035 m0_axis_tready held 0 for 5 cycles during a port-0 packet -> s_axis_tready drops after 2 beats are buffered, m0 data stays stable, and no beat is lost after release.
REQ-036 Port-1 packet stalled at the head, then a port-0 packet offered -> no m0_axis_tvalid until the port-1 packet drains.
REQ-037 pkt_cnt0 preloaded near 0xFFFF by sending 65536 single-beat packets -> pkt_cnt0 wraps to 0.
REQ-038 axis_aresetn pulsed low after beat 2 of a 4-beat packet -> outputs return to reset values, and the next beat with tdest=1 routes to m1.
